decoder_rr_arbiter: RTL

- Round-robin arbiter that shares one 3-to-8 decoder between eight requesters.
- Drives the decoder's 3-bit select and its active-low enable, and mirrors the decoded one-hot grant for local use.
- Sits directly in front of the decoder and owns the enable: the decoder is enabled only while exactly one requester holds the grant.

---
 rtl/decoder_rr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among eight requesters; owns the decoder enable.
// Optional hold-time limit built only when ARB_TIMEOUT_EN is defined (HOLD_MAX cycles per grant).
module decoder_rr_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] grant_idx,
    output logic       grant_en_n,
    output logic [7:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] grant_idx_q, grant_idx_d;
    logic       grant_en_n_q, grant_en_n_d;
    logic [7:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       pick_vld;
    logic [2:0] pick_idx;
    logic       rel;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
`endif

    // Scan from the highest offset down so the closest set bit after ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr_q + 3'(i)]) begin
                pick_vld = 1'b1;
                pick_idx = ptr_q + 3'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_idx_d  = grant_idx_q;
        grant_en_n_d = grant_en_n_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        rel          = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d   = hold_cnt_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_idx_d  = pick_idx;
                    grant_en_n_d = 1'b0;
                    grant_d      = 8'b1 << pick_idx;
                    busy_d       = 1'b1;
                    ptr_d        = pick_idx + 3'd1;
                    state_d      = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d   = 8'd0;
`endif
                end else begin
                    grant_idx_d = 3'd0;
                end
            end
            GRANT: begin
                rel = done || !req[grant_idx_q];
`ifdef ARB_TIMEOUT_EN
                // A normal release on the same edge suppresses the timeout pulse.
                if (!rel && hold_cnt_q == HOLD_LAST) begin
                    rel       = 1'b1;
                    timeout_d = 1'b1;
                end else if (!rel) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
`endif
                if (rel) begin
                    grant_en_n_d = 1'b1;
                    grant_d      = 8'h00;
                    busy_d       = 1'b0;
                    state_d      = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 3'd0;
            grant_idx_q  <= 3'd0;
            grant_en_n_q <= 1'b1;
            grant_q      <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_idx_q  <= grant_idx_d;
            grant_en_n_q <= grant_en_n_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant_idx  = grant_idx_q;
    assign grant_en_n = grant_en_n_q;
    assign grant      = grant_q;
    assign busy       = busy_q;

endmodule
